// File: rtl/demap_sequencer.sv
// ============================================================================
// demap_sequencer : per-OFDM-symbol demapper controller and LSB-first bit serializer
// Optional feature macro: DEMAP_SYMCNT_EN (symbol counter + sticky start error)
// Revision: 1.0
// ============================================================================
`default_nettype none

module demap_sequencer #(
    parameter int NSC = 48
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mod_in,
    input  logic       sc_valid,
    output logic       sc_ready,
    input  logic [7:0] sc_data,
    output logic [7:0] dm_x,
    output logic [1:0] dm_mod,
    input  logic [5:0] dm_bits,
    output logic       out_bit,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy,
    output logic       done
`ifdef DEMAP_SYMCNT_EN
    ,
    output logic [15:0] sym_cnt,
    output logic [0:0]  err_start
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CAPT  = 2'd2,
        SHIFT = 2'd3
    } state_t;

    localparam logic [5:0] LAST_SC = 6'(NSC - 1);

    state_t     state, state_nx;
    logic [1:0] mod_q;
    logic [7:0] x_q;
    logic [5:0] sh;
    logic [2:0] bit_cnt;
    logic [5:0] sc_cnt;
    logic       done_q;

    logic [2:0] nbpsc;
    logic [5:0] bit_mask;
    logic       last_bit, last_sc;
    logic       latch_mod, take_pt, capt, bit_inc, sc_inc, fin;

    always_comb begin
        case (mod_q)
            2'd0:    begin nbpsc = 3'd1; bit_mask = 6'b000001; end
            2'd1:    begin nbpsc = 3'd2; bit_mask = 6'b000011; end
            2'd2:    begin nbpsc = 3'd4; bit_mask = 6'b001111; end
            default: begin nbpsc = 3'd6; bit_mask = 6'b111111; end
        endcase
    end

    assign last_bit = (bit_cnt == nbpsc - 3'd1);
    assign last_sc  = (sc_cnt == LAST_SC);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        sc_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        busy      = (state != IDLE);
        latch_mod = 1'b0;
        take_pt   = 1'b0;
        capt      = 1'b0;
        bit_inc   = 1'b0;
        sc_inc    = 1'b0;
        fin       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    latch_mod = 1'b1;
                    state_nx  = LOAD;
                end
            end
            LOAD: begin
                sc_ready = 1'b1;
                if (sc_valid) begin
                    take_pt  = 1'b1;
                    state_nx = CAPT;
                end
            end
            CAPT: begin
                capt     = 1'b1;
                state_nx = SHIFT;
            end
            SHIFT: begin
                out_valid = 1'b1;
                out_bit   = sh[bit_cnt];
                out_last  = last_bit && last_sc;
                if (out_ready) begin
                    if (!last_bit) begin
                        bit_inc = 1'b1;
                    end else if (!last_sc) begin
                        sc_inc   = 1'b1;
                        state_nx = LOAD;
                    end else begin
                        fin      = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_q   <= 2'd0;
            x_q     <= 8'd0;
            sh      <= 6'd0;
            bit_cnt <= 3'd0;
            sc_cnt  <= 6'd0;
            done_q  <= 1'b0;
        end else begin
            done_q <= fin;
            if (latch_mod) begin
                mod_q  <= mod_in;
                sc_cnt <= 6'd0;
            end
            if (take_pt) x_q <= sc_data;
            if (capt) begin
                sh      <= dm_bits & bit_mask;
                bit_cnt <= 3'd0;
            end
            if (bit_inc) bit_cnt <= bit_cnt + 3'd1;
            if (sc_inc)  sc_cnt  <= sc_cnt + 6'd1;
        end
    end

    assign dm_x   = x_q;
    assign dm_mod = mod_q;
    assign done   = done_q;

`ifdef DEMAP_SYMCNT_EN
    // Counter steps on the same edge that raises done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt   <= 16'd0;
            err_start <= 1'b0;
        end else begin
            if (fin) sym_cnt <= sym_cnt + 16'd1;
            if (start && (state != IDLE)) err_start <= 1'b1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_demap_sequencer.sv
// ============================================================================
// tb_demap_sequencer : scoreboard bench with a behavioural demapper model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_demap_sequencer;

    localparam int NSC = 48;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mod_in = 2'd0;
    logic       sc_valid = 1'b0;
    logic       sc_ready;
    logic [7:0] sc_data = 8'd0;
    logic [7:0] dm_x;
    logic [1:0] dm_mod;
    logic [5:0] dm_bits;
    logic       out_bit, out_valid, out_last, busy, done;
    logic       out_ready = 1'b0;
`ifdef DEMAP_SYMCNT_EN
    logic [15:0] sym_cnt;
    logic [0:0]  err_start;
`endif

    int errors = 0;
    int checks = 0;
    bit abort  = 0;
    logic [1:0] exp_q[$];   // {last, bit}

    always #5 clk = ~clk;

    demap_sequencer #(.NSC(NSC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mod_in(mod_in),
        .sc_valid(sc_valid), .sc_ready(sc_ready), .sc_data(sc_data),
        .dm_x(dm_x), .dm_mod(dm_mod), .dm_bits(dm_bits),
        .out_bit(out_bit), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .done(done)
`ifdef DEMAP_SYMCNT_EN
        , .sym_cnt(sym_cnt), .err_start(err_start)
`endif
    );

    // External demapper stand-in; upper bits carry junk the sequencer must ignore.
    function automatic logic [5:0] demap(input logic [7:0] x, input logic [1:0] m);
        case (x)
            8'h70:   return 6'b110101;
            8'h08:   return 6'b011001;
            8'h19:   return 6'b101011;
            8'h3D:   return 6'b100111;
            default: return x[5:0] ^ {x[7:6], x[7:4]} ^ {4'b0, m};
        endcase
    endfunction

    always_comb dm_bits = demap(dm_x, dm_mod);

    function automatic int nbpsc(input logic [1:0] m);
        case (m)
            2'd0:    return 1;
            2'd1:    return 2;
            2'd2:    return 4;
            default: return 6;
        endcase
    endfunction

    task automatic pulse_start(input logic [1:0] m);
        @(posedge clk); #1;
        start = 1'b1; mod_in = m;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_points(input logic [1:0] m, input logic [7:0] fixd,
                                input bit rnd_data, input bit rnd_flow);
        int nb = nbpsc(m);
        for (int p = 0; p < NSC; p++) begin
            logic [7:0] d;
            logic [5:0] w;
            int wt;
            if (abort) break;
            if (rnd_flow) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            d = rnd_data ? 8'($urandom) : fixd;
            sc_valid = 1'b1;
            sc_data  = d;
            wt = 0;
            @(negedge clk);
            while (!sc_ready && wt < 100) begin @(negedge clk); wt++; end
            if (!sc_ready) begin
                errors++; checks++;
                $display("FAIL sc_ready_timeout point=%0d got sc_ready=%b want 1", p, sc_ready);
                abort = 1;
                break;
            end
            @(posedge clk);
            w = demap(d, m);
            for (int b = 0; b < nb; b++)
                exp_q.push_back({(p == NSC - 1) && (b == nb - 1), w[b]});
            #1;
            sc_valid = 1'b0;
        end
    endtask

    task automatic consume(input logic [1:0] m, input bit rnd_flow,
                           input int exp_ones, input string name);
        int total = NSC * nbpsc(m);
        int got = 0, ones = 0, cyc = 0;
        bit held = 0;
        logic hb = 1'b0, hl = 1'b0;
        logic [1:0] e;
        while (got < total && cyc < 5000 && !abort) begin
            @(posedge clk); #1;
            out_ready = rnd_flow ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            cyc++;
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || out_bit !== hb || out_last !== hl) begin
                    errors++;
                    $display("FAIL %s stall_hold got v=%b b=%b l=%b want v=1 b=%b l=%b",
                             name, out_valid, out_bit, out_last, hb, hl);
                end
            end
            held = 0;
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL %s unexpected_bit idx=%0d got bit=%b want none", name, got, out_bit);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_last, out_bit} !== e) begin
                            errors++;
                            $display("FAIL %s bit idx=%0d got last/bit=%b%b want %b%b",
                                     name, got, out_last, out_bit, e[1], e[0]);
                        end
                    end
                    if (out_bit === 1'b1) ones++;
                    got++;
                end else begin
                    held = 1; hb = out_bit; hl = out_last;
                end
            end
        end
        checks++;
        if (got != total) begin
            errors++;
            $display("FAIL %s bit_count got %0d want %0d", name, got, total);
            abort = 1;
        end
        if (exp_ones >= 0) begin
            checks++;
            if (ones != exp_ones) begin
                errors++;
                $display("FAIL %s ones got %0d want %0d", name, ones, exp_ones);
            end
        end
        if (!abort) begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s done_pulse got done=%b busy=%b v=%b want 1 0 0", name, done, busy, out_valid);
            end
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || exp_q.size() != 0) begin
                errors++;
                $display("FAIL %s done_clear got done=%b left=%0d want 0 0", name, done, exp_q.size());
            end
        end
    endtask

    task automatic inject_start(input logic [1:0] m);
        int wt = 0;
        @(negedge clk);
        while (!out_valid && wt < 200) begin @(negedge clk); wt++; end
        @(posedge clk); #1;
        start = 1'b1; mod_in = 2'd3;
        @(posedge clk); #1;
        start = 1'b0; mod_in = m;
        @(negedge clk);
        checks++;
        if (dm_mod !== m || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored got dm_mod=%0d busy=%b want %0d 1", dm_mod, busy, m);
        end
    endtask

    task automatic run_symbol(input logic [1:0] m, input logic [7:0] fixd, input bit rnd_data,
                              input bit rnd_flow, input bit inject, input int exp_ones,
                              input string name);
        exp_q.delete();
        abort = 0;
        pulse_start(m);
        fork
            drive_points(m, fixd, rnd_data, rnd_flow);
            consume(m, rnd_flow, exp_ones, name);
            if (inject) inject_start(m);
        join
        sc_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if ({sc_ready, out_valid, out_last, busy, done, out_bit, dm_x, dm_mod} !== 15'd0) begin
            errors++;
            $display("FAIL reset_values got %b want all zero",
                     {sc_ready, out_valid, out_last, busy, done, out_bit, dm_x, dm_mod});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_modes();
        run_symbol(2'd0, 8'h70, 0, 0, 0, 48,  "bpsk");
        run_symbol(2'd1, 8'h08, 0, 0, 0, 48,  "qpsk");
        run_symbol(2'd2, 8'h19, 0, 0, 0, 144, "qam16");
        run_symbol(2'd3, 8'h3D, 0, 0, 0, 192, "qam64");
    endtask

    task automatic test_random_flow();
        run_symbol(2'd2, 8'h00, 1, 1, 0, -1, "rand_qam16");
        run_symbol(2'd3, 8'h00, 1, 1, 0, -1, "rand_qam64");
        run_symbol(2'd1, 8'h00, 1, 1, 0, -1, "rand_qpsk");
    endtask

    task automatic test_start_ignored();
        run_symbol(2'd1, 8'h00, 1, 1, 1, -1, "start_busy");
    endtask

    task automatic test_reset_mid();
        int wt = 0;
        pulse_start(2'd3);
        out_ready = 1'b0;
        sc_valid = 1'b1; sc_data = 8'h3D;
        @(negedge clk);
        while (!out_valid && wt < 50) begin @(negedge clk); wt++; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_reach_shift got v=%b want 1", out_valid);
        end
        rst_n = 1'b0;
        sc_valid = 1'b0;
        #1;
        checks++;
        if ({sc_ready, out_valid, out_last, busy, done, out_bit, dm_x, dm_mod} !== 15'd0) begin
            errors++;
            $display("FAIL mid_reset_values got %b want all zero",
                     {sc_ready, out_valid, out_last, busy, done, out_bit, dm_x, dm_mod});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_no_done got done=%b busy=%b want 0 0", done, busy);
            end
        end
        run_symbol(2'd0, 8'h70, 0, 0, 0, 48, "after_reset");
    endtask

    initial begin
        test_reset();
        test_modes();
        test_random_flow();
        test_start_ignored();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
